fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage that feeds the decode stage. It holds the PC and issues word requests to instruction memory over a req/gnt/rvalid interface. Returned words are buffered in a small in-order queue and presented to decode with a valid/ready handshake. Branch/jump redirects (PCSrc/PCTarget) flush the queue and discard in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset.
DEPTH, 4, instruction queue entries and in-flight request limit; power of two, at least 2.

Ports:
clk  in  1  clock, all state updates on rising edge.
reset  in  1  synchronous, active-low reset.
PCSrc  in  1  redirect request, valid for one cycle.
PCTarget  in  32  redirect target address.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch word address; bits [1:0] always 00.
imem_gnt  in  1  request accepted this cycle; a transaction is imem_req&imem_gnt.
imem_rvalid  in  1  read data valid; responses return in order, at least 1 cycle after gnt.
imem_rdata  in  32  read data.
instr_valid  out  1  queue head valid to decode.
instr_ready  in  1  decode accepts head.
instr  out  32  head instruction; 32'h0000_0013 (NOP) when instr_valid=0.
instr_pc  out  32  address of head instruction.
instr_pcplus4  out  32  instr_pc+4, modulo 2^32.

Behaviour:
- Reset (reset=0 at edge): pc=RESET_PC, queue empty, inflight=0, discard=0. While reset=0: imem_req=0, instr_valid=0, instr=NOP, imem_addr=RESET_PC, instr_pc=instr_pcplus4=0.
- imem_addr = pc. imem_req=1 when (inflight + discard + queue_count) < DEPTH and reset=1; counts are registered values (no same-cycle credit from pops or returns).
- On transaction: pc <= pc+4 (wraps at 2^32), inflight++. Address stays stable while req=1 without gnt, except on redirect.
- On imem_rvalid: if discard>0, word dropped, discard--; else push {imem_rdata, its address} to queue, inflight--. Each queue entry carries its own PC.
- rvalid with inflight=0 and discard=0: ignored, no state change.
- Latency: gnt at cycle t, rvalid at t+1 gives instr_valid at t+2. With gnt always 1, rvalid one cycle later and ready=1: one instruction per cycle sustained at DEPTH=4.
- instr_valid = queue non-empty & ~PCSrc. Pop on instr_valid&instr_ready. Queue never overflows (credit rule).
- Redirect (PCSrc=1): pc <= {PCTarget[31:2],2'b00}. Queue flushed; no pop that cycle. discard <= discard + inflight + (gnt this cycle) - (rvalid this cycle). inflight <= 0. A rvalid in the redirect cycle is dropped. An un-granted request is abandoned; next cycle's request uses the new target.
- Simultaneous push and pop with queue full is not possible under the credit rule; push and pop on a partially filled queue are both applied.
- Reset mid-operation: all counts cleared. Memory shares the same reset, so no stale responses follow.

Test Plan:
1. Release reset, gnt=1, rvalid one cycle after gnt, rdata=addr^32'hA5A5_0000, ready=1 -> imem_addr 0,4,8,... on consecutive cycles; instr_valid first high 2 cycles after first gnt; instr_pc 0,4,8 back-to-back with matching data; pcplus4 correct.
2. Hold instr_ready=0 -> after 4 transactions imem_req=0 and queue holds 0x0..0xC; raise ready -> 0x0,0x4,0x8,0xC pop in order, then fetch resumes at 0x10.
3. Two requests in flight (0x20, 0x24), pulse PCSrc with PCTarget=0x100 -> next imem_addr=0x100; the two later rvalids are dropped; first instr_valid has instr_pc=0x100.
4. PCSrc in the same cycle as gnt(0x30) and rvalid(0x2C), queue holding one entry -> both words discarded, queue empty, instr_valid=0 that cycle, fetch restarts at target.
5. PCTarget=0x0000_0102 -> imem_addr=0x100. Streaming from pc=0xFFFF_FFFC -> next address 0x0000_0000, pcplus4=0.
6. Assert reset=0 for one cycle with a full queue and ready=0 -> next cycle instr_valid=0, instr=NOP. After release, the first request is RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word requests to instruction memory, queues
// returned words in order and hands them to decode; redirects flush the queue.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [CW+1:0] DEPTH_W = (CW+2)'(DEPTH);

  logic [31:0]   pc_r, pc_s;
  logic [CW-1:0] inflight_r, inflight_s;
  logic [CW-1:0] discard_r, discard_s;
  logic [CW-1:0] count_r, count_s;
  logic [AW-1:0] head_r, head_s, tail_r, tail_s;
  logic [31:0]   q_data_r [DEPTH];
  logic [31:0]   q_pc_r   [DEPTH];

  logic [CW+1:0] credit_s;
  logic          txn_s, rv_drop_s, rv_take_s, pop_s, has_head_s;
  logic [31:0]   rsp_pc_s;

  // Request credit, handshake decode and output presentation.
  always_comb begin
    credit_s      = {2'b00, inflight_r} + {2'b00, discard_r} + {2'b00, count_r};
    imem_req      = reset && (credit_s < DEPTH_W);
    imem_addr     = reset ? pc_r : RESET_PC;
    txn_s         = imem_req && imem_gnt;
    rv_drop_s     = imem_rvalid && (discard_r != {CW{1'b0}});
    rv_take_s     = imem_rvalid && (discard_r == {CW{1'b0}}) && (inflight_r != {CW{1'b0}});
    has_head_s    = reset && (count_r != {CW{1'b0}});
    instr_valid   = has_head_s && !PCSrc;
    pop_s         = instr_valid && instr_ready;
    instr         = instr_valid ? q_data_r[head_r] : NOP;
    instr_pc      = has_head_s ? q_pc_r[head_r] : 32'h0000_0000;
    instr_pcplus4 = has_head_s ? (q_pc_r[head_r] + 32'd4) : 32'h0000_0000;
    // Live requests are consecutive words ending just below pc, so the oldest is pc - 4*inflight.
    rsp_pc_s      = pc_r - (32'(inflight_r) << 2);
  end

  // Next-state computation for pc, counters and queue pointers.
  always_comb begin
    pc_s       = pc_r;
    inflight_s = inflight_r;
    discard_s  = discard_r;
    count_s    = count_r;
    head_s     = head_r;
    tail_s     = tail_r;
    if (PCSrc) begin
      pc_s       = {PCTarget[31:2], 2'b00};
      inflight_s = {CW{1'b0}};
      discard_s  = discard_r + inflight_r + CW'(txn_s) - CW'(rv_drop_s || rv_take_s);
      count_s    = {CW{1'b0}};
      head_s     = {AW{1'b0}};
      tail_s     = {AW{1'b0}};
    end else begin
      if (txn_s) begin
        pc_s = pc_r + 32'd4;
      end else begin
        pc_s = pc_r;
      end
      inflight_s = inflight_r + CW'(txn_s) - CW'(rv_take_s);
      discard_s  = discard_r - CW'(rv_drop_s);
      count_s    = count_r + CW'(rv_take_s) - CW'(pop_s);
      tail_s     = rv_take_s ? (tail_r + ONE_A) : tail_r;
      head_s     = pop_s ? (head_r + ONE_A) : head_r;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_r       <= RESET_PC;
      inflight_r <= {CW{1'b0}};
      discard_r  <= {CW{1'b0}};
      count_r    <= {CW{1'b0}};
      head_r     <= {AW{1'b0}};
      tail_r     <= {AW{1'b0}};
    end else begin
      pc_r       <= pc_s;
      inflight_r <= inflight_s;
      discard_r  <= discard_s;
      count_r    <= count_s;
      head_r     <= head_s;
      tail_r     <= tail_s;
    end
  end

  // Queue storage; only the accepted-response path writes it.
  always_ff @(posedge clk) begin
    if (reset && !PCSrc && rv_take_s) begin
      q_data_r[tail_r] <= imem_rdata;
      q_pc_r[tail_r]   <= rsp_pc_s;
    end
  end

endmodule
